// File: rtl/tim6_pkg.sv
// Shared definitions for the TIM6 basic timer: CR1 bit layout and default width.
package tim6_pkg;

    localparam int W_DEFAULT = 16;

    localparam int CR1_CEN  = 0;
    localparam int CR1_UDIS = 1;
    localparam int CR1_URS  = 2;
    localparam int CR1_OPM  = 3;
    localparam int CR1_ARPE = 4;
    localparam int CR1_W    = 5;

    // Field order mirrors the CR1_* indices above (cen is bit 0).
    typedef struct packed {
        logic arpe;
        logic opm;
        logic urs;
        logic udis;
        logic cen;
    } cr1_t;

endpackage

// File: rtl/tim6_prescaler.sv
// Prescaler: divides the block clock by psc_sh+1 and emits a one-cycle tick.
module tim6_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run_i,
    input  logic         ug_i,
    input  logic         load_i,
    input  logic [W-1:0] psc_i,
    output logic         tick_o
);

    logic [W-1:0] psc_cnt_q, psc_cnt_d;
    logic [W-1:0] psc_sh_q, psc_sh_d;
    logic         wrap;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        wrap      = (psc_cnt_q == psc_sh_q);
        tick_o    = run_i & ~ug_i & wrap;
        psc_cnt_d = psc_cnt_q;
        if (ug_i) begin
            psc_cnt_d = '0;
        end else if (run_i) begin
            psc_cnt_d = wrap ? '0 : psc_cnt_q + 1'b1;
        end
        psc_sh_d = load_i ? psc_i : psc_sh_q;
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt_q <= '0;
            psc_sh_q  <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
            psc_sh_q  <= psc_sh_d;
        end
    end

endmodule

// File: rtl/tim6_counter.sv
// TIM6-style basic up-counter: auto-reload with optional shadowing, update
// event and flag generation, and one-pulse mode.
module tim6_counter
    import tim6_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CR1_W-1:0] i_tim6_cr1,
    input  logic [W-1:0]     i_psc,
    input  logic [W-1:0]     i_arr,
    input  logic             i_ug,
    input  logic             i_uif_clr,
    output logic [W-1:0]     o_cnt,
    output logic             o_uif,
    output logic             o_uev,
    output logic             o_cen_clr
);

    cr1_t         cr1;
    logic         run, tick, overflow, uev_d, uif_set, opm_set;
    logic [W-1:0] arr_eff;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] arr_sh_q, arr_sh_d;
    logic         uif_q, uif_d;
    logic         uev_q;
    logic         cen_clr_q, cen_clr_d;
    logic         opm_stop_q, opm_stop_d;

    assign cr1 = cr1_t'(i_tim6_cr1);
    assign run = cr1.cen & ~opm_stop_q;

    tim6_prescaler #(.W(W)) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_i  (run),
        .ug_i   (i_ug),
        .load_i (uev_d),
        .psc_i  (i_psc),
        .tick_o (tick)
    );

    always_comb begin
        arr_eff  = cr1.arpe ? arr_sh_q : i_arr;
        // All-ones also wraps, which covers ARR lowered below the running count.
        overflow = tick & ((cnt_q == arr_eff) | (&cnt_q));
        uev_d    = ~cr1.udis & (i_ug | overflow);
        uif_set  = uev_d & (overflow | ~cr1.urs);
        opm_set  = uev_d & overflow & cr1.opm;

        cnt_d = cnt_q;
        if (i_ug) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = overflow ? '0 : cnt_q + 1'b1;
        end

        arr_sh_d   = uev_d ? i_arr : arr_sh_q;
        uif_d      = uif_set | (uif_q & ~i_uif_clr);
        opm_stop_d = cr1.cen & (opm_stop_q | opm_set);
        cen_clr_d  = opm_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            arr_sh_q   <= '1;
            uif_q      <= 1'b0;
            uev_q      <= 1'b0;
            cen_clr_q  <= 1'b0;
            opm_stop_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            arr_sh_q   <= arr_sh_d;
            uif_q      <= uif_d;
            uev_q      <= uev_d;
            cen_clr_q  <= cen_clr_d;
            opm_stop_q <= opm_stop_d;
        end
    end

    assign o_cnt     = cnt_q;
    assign o_uif     = uif_q;
    assign o_uev     = uev_q;
    assign o_cen_clr = cen_clr_q;

endmodule
